// File: rtl/spi_master.sv
// SPI mode-0 master: per-transfer length, clock divider and slave-select mask.
// Define SPI_MASTER_LSB_FIRST_EN to shift data LSB-first instead of MSB-first.
module spi_master #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5,
    parameter int DIV_W  = 8,
    parameter int SS_N   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DIV_W-1:0]  req_div,
    input  logic [SS_N-1:0]   req_ss,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              sck,
    output logic [SS_N-1:0]   ss_n,
    output logic              mosi,
    input  logic              miso
);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, RESP} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  half_q, half_d;
    logic [LEN_W-1:0]  bits_q, bits_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [SS_N-1:0]   ss_n_q, ss_n_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [LEN_W-1:0]  len_eff;
    logic [DATA_W-1:0] rx_sampled;

    function automatic logic lead_bit(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    // NOTE: every _d gets a default first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        half_d       = half_q;
        bits_d       = bits_q;
        len_d        = len_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        ss_n_d       = ss_n_q;
        sck_d        = sck_q;
        mosi_d       = mosi_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;

        len_eff = (req_len == '0 || req_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : req_len;
        // MSB-first appends at bit 0; LSB-first inserts at bit len-1 and drifts right.
        rx_sampled = LSB_FIRST ? ((rx_q >> 1) | (DATA_W'(miso) << (len_q - 1'b1)))
                               : {rx_q[DATA_W-2:0], miso};

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = SETUP;
                    req_ready_d = 1'b0;
                    div_d       = req_div;
                    half_d      = req_div;
                    bits_d      = len_eff;
                    len_d       = len_eff;
                    tx_d        = LSB_FIRST ? req_data
                                            : req_data << (DATA_W - int'(len_eff));
                    rx_d        = '0;
                    ss_n_d      = ~req_ss;
                    mosi_d      = lead_bit(tx_d);
                end
            end
            SETUP: begin
                if (half_q == '0) begin
                    state_d = SHIFT;
                    half_d  = div_q;
                    sck_d   = 1'b1;
                    rx_d    = rx_sampled;
                end else begin
                    half_d = half_q - 1'b1;
                end
            end
            SHIFT: begin
                if (half_q != '0) begin
                    half_d = half_q - 1'b1;
                end else begin
                    half_d = div_q;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (bits_q != LEN_W'(1)) begin
                            tx_d   = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
                            mosi_d = lead_bit(tx_d);
                        end
                    end else if (bits_q == LEN_W'(1)) begin
                        state_d      = RESP;
                        ss_n_d       = '1;
                        mosi_d       = 1'b1;
                        resp_valid_d = 1'b1;
                    end else begin
                        bits_d = bits_q - 1'b1;
                        sck_d  = 1'b1;
                        rx_d   = rx_sampled;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            half_q       <= '0;
            bits_q       <= '0;
            len_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            ss_n_q       <= '1;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b1;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            half_q       <= half_d;
            bits_q       <= bits_d;
            len_q        <= len_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            ss_n_q       <= ss_n_d;
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = rx_q;
    assign sck        = sck_q;
    assign ss_n       = ss_n_q;
    assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: directed vector table plus randomized transfers
// checked against a bit-sequence reference model.
module tb_spi_master;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;
    localparam int DIV_W  = 8;
    localparam int SS_N   = 8;
    localparam int LOOP = 0, ONES = 1, RAND = 2;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic [LEN_W-1:0]  req_len;
    logic [DIV_W-1:0]  req_div;
    logic [SS_N-1:0]   req_ss;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              sck;
    logic [SS_N-1:0]   ss_n;
    logic              mosi;
    logic              miso;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          slave_mode = LOOP;
    logic [15:0] slave_word = '0;
    int          slave_idx  = 0;

    spi_master #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W), .SS_N(SS_N)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_len(req_len), .req_div(req_div), .req_ss(req_ss),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    always #5 clock = ~clock;

    // Slave model: loopback, constant one, or a word presented bit 0 first, advancing on sck fall.
    assign miso = (slave_mode == LOOP) ? mosi :
                  (slave_mode == ONES) ? 1'b1 : slave_word[slave_idx[3:0]];
    always @(negedge sck) slave_idx = slave_idx + 1;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  len;
        logic [7:0]  div;
        logic [7:0]  ss;
        int          mode;
        int          hold;
        logic [15:0] exp_data;
        int          exp_cycle;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int eff_len(input logic [4:0] len);
        return (len == 0 || len > DATA_W) ? DATA_W : int'(len);
    endfunction

    // i-th bit on the wire (i = 0 is the first bit sent)
    function automatic logic tx_bit(input logic [15:0] data, input int n, input int i);
        return LSB_FIRST ? data[i] : data[n-1-i];
    endfunction

    function automatic logic [15:0] model_resp(input logic [15:0] data, input logic [4:0] len,
                                               input int mode, input logic [15:0] sbits);
        int          n;
        logic        b;
        logic [15:0] r;
        n = eff_len(len);
        r = '0;
        for (int i = 0; i < n; i++) begin
            b = (mode == LOOP) ? tx_bit(data, n, i) : (mode == ONES) ? 1'b1 : sbits[i];
            if (LSB_FIRST) r[i] = b;
            else           r[n-1-i] = b;
        end
        return r;
    endfunction

    function automatic logic exp_sck(input int c, input int h, input int n);
        if (c < 1 + h || c >= 1 + h + 2 * n * h) return 1'b0;
        return ((c - 1 - h) % (2 * h)) < h;
    endfunction

    function automatic logic exp_mosi(input logic [15:0] data, input int c, input int h, input int n);
        int i;
        i = (c - 1) / (2 * h);
        if (i > n - 1) i = n - 1;
        return tx_bit(data, n, i);
    endfunction

    // Called just after a negedge with the DUT idle. Cycle c is the value seen
    // at the negedge after edge c-1, with the accept edge being edge 0.
    task automatic run_xfer(input string tag, input logic [15:0] data, input logic [4:0] len,
                            input logic [7:0] div, input logic [7:0] ss, input int mode,
                            input logic [15:0] sbits, input int hold,
                            input logic [15:0] exp_data, input int exp_cycle);
        int          n, h, cyc, limit;
        int          bad_ss, bad_sck, bad_mosi, bad_rdy, bad_hold;
        logic [15:0] held;
        n = eff_len(len);
        h = int'(div) + 1;
        limit = 1 + h + 2 * n * h + 8;
        bad_ss = 0; bad_sck = 0; bad_mosi = 0; bad_rdy = 0; bad_hold = 0;
        slave_mode = mode;
        slave_word = sbits;
        slave_idx  = 0;
        req_data = data; req_len = len; req_div = div; req_ss = ss;
        req_valid = 1'b1; resp_ready = 1'b0;
        check({tag, " req_ready_idle"}, req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_data = 16'($urandom); req_len = 5'($urandom); req_div = 8'($urandom); req_ss = 8'($urandom);
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < limit) begin
            if (ss_n !== ~ss)                      bad_ss++;
            if (sck !== exp_sck(cyc, h, n))        bad_sck++;
            if (mosi !== exp_mosi(data, cyc, h, n)) bad_mosi++;
            if (req_ready !== 1'b0)                bad_rdy++;
            @(negedge clock);
            cyc++;
        end
        check({tag, " ss_n_active"}, bad_ss, 0);
        check({tag, " sck_wave"}, bad_sck, 0);
        check({tag, " mosi_wave"}, bad_mosi, 0);
        check({tag, " req_ready_busy"}, bad_rdy, 0);
        check({tag, " resp_cycle"}, cyc, exp_cycle);
        check({tag, " resp_data"}, resp_data, exp_data);
        check({tag, " resp_lines"}, {sck, ss_n, mosi}, {1'b0, 8'hFF, 1'b1});
        held = resp_data;
        for (int j = 0; j < hold; j++) begin
            req_valid = 1'b1;
            req_data = 16'($urandom); req_len = 5'd8; req_div = 8'd0; req_ss = 8'h01;
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 1'b0 ||
                ss_n !== 8'hFF || sck !== 1'b0 || mosi !== 1'b1) bad_hold++;
        end
        if (hold > 0) check({tag, " resp_hold"}, bad_hold, 0);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        check({tag, " handshake"}, {req_ready, resp_valid, ss_n}, {1'b1, 1'b0, 8'hFF});
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] rdata, rsbits;
        logic [4:0]  rlen;
        logic [7:0]  rdiv, rss;
        int          rmode, cyc, seen;

        vecs[0] = '{16'h00A5, 5'd8,  8'd0, 8'h01, LOOP, 0,  16'h00A5, 18};
        vecs[1] = '{16'h1234, 5'd16, 8'd3, 8'h02, ONES, 10, 16'hFFFF, 133};
        vecs[2] = '{16'h1234, 5'd0,  8'd0, 8'h80, LOOP, 0,  16'h1234, 34};
        vecs[3] = '{16'hBEEF, 5'd20, 8'd1, 8'h0C, LOOP, 2,  16'hBEEF, 67};
        vecs[4] = '{16'h0001, 5'd8,  8'd0, 8'h01, LOOP, 0,  16'h0001, 18};
        vecs[5] = '{16'h00FF, 5'd1,  8'd2, 8'h00, ONES, 0,  16'h0001, 10};

        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_data = '0; req_len = '0; req_div = '0; req_ss = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_data", resp_data, 0);
        check("reset sck", sck, 0);
        check("reset ss_n", ss_n, 8'hFF);
        check("reset mosi", mosi, 1);

        for (int v = 0; v < 6; v++)
            run_xfer($sformatf("vec%0d", v), vecs[v].data, vecs[v].len, vecs[v].div, vecs[v].ss,
                     vecs[v].mode, 16'h0000, vecs[v].hold, vecs[v].exp_data, vecs[v].exp_cycle);

        // Reset pulse sampled at edge 7 of a len=8, div=0 transfer.
        slave_mode = LOOP;
        req_data = 16'h00A5; req_len = 5'd8; req_div = 8'd0; req_ss = 8'h01; req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            @(negedge clock);
            cyc++;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort lines", {sck, ss_n, mosi, req_ready}, {1'b0, 8'hFF, 1'b1, 1'b1});
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            if (resp_valid !== 1'b0) seen++;
        end
        check("abort no_resp", seen, 0);
        check("abort resp_data", resp_data, 0);

        for (int r = 0; r < 12; r++) begin
            rdata  = 16'($urandom);
            rlen   = 5'($urandom_range(0, 20));
            rdiv   = 8'($urandom_range(0, 3));
            rss    = 8'($urandom);
            rmode  = int'($urandom_range(0, 2));
            rsbits = 16'($urandom);
            run_xfer($sformatf("rnd%0d", r), rdata, rlen, rdiv, rss, rmode, rsbits,
                     int'($urandom_range(0, 3)), model_resp(rdata, rlen, rmode, rsbits),
                     1 + (int'(rdiv) + 1) * (1 + 2 * eff_len(rlen)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Single-channel SPI mode-0 master for the NPC peripheral subsystem. It is the initiator counterpart of the SPI slave peripherals: it drives `sck`, active-low slave selects and `mosi`, and samples `miso`. A core-side valid/ready request/response interface carries 1..DATA_W-bit transfers. Each transfer carries its own clock divider and slave-select mask.

## Interface
- `DATA_W`, 16: maximum bits per transfer; also the width of the request and response data.
- `LEN_W`, 5: width of `req_len`; must hold DATA_W.
- `DIV_W`, 8: width of `req_div`.
- `SS_N`, 8: number of slave-select lines.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  transfer request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_data`  in  DATA_W  transmit bits, right-aligned.
- `req_len`  in  LEN_W  bit count; 0 or >DATA_W is clamped to DATA_W.
- `req_div`  in  DIV_W  half-period H = req_div+1 clock cycles.
- `req_ss`  in  SS_N  one-hot or multi-hot select mask; 0 runs the transfer with no slave selected.
- `resp_valid`  out  1  received data valid.
- `resp_ready`  in  1  response accepted.
- `resp_data`  out  DATA_W  received bits, right-aligned; bits ≥ len are zero.
- `sck`  out  1  SPI clock, idles low.
- `ss_n`  out  SS_N  active-low selects, idle all-ones.
- `mosi`  out  1  master out, idles 1.
- `miso`  in  1  slave out.

## Operation
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `sck`=0, `ss_n`=all ones, `mosi`=1, FSM=IDLE.
- Reset asserted mid-transfer aborts the transfer. Outputs take their reset values on the next edge. No response is produced.
- States:
  - IDLE: latch req_data, the clamped len, div and ss on `req_valid && req_ready`, then go to SETUP.
  - SETUP: H cycles with `ss_n`=~ss, `sck`=0, and `mosi` holding the first bit. Then go to SHIFT.
  - SHIFT: len bit periods. Each period is H cycles with `sck`=1, then H cycles with `sck`=0. After the final low half, go to RESP.
  - RESP: `ss_n` is all ones, `resp_valid`=1, `mosi`=1. Hold until `resp_ready`, then go to IDLE.
- Bit order: MSB-first. The first bit is req_data[len-1] and the last is req_data[0].
- Sampling: `miso` is sampled on the clock edge that drives `sck` 0→1.
- Shifting: the sample enters at the LSB of the receive shift register. `mosi` advances on the edge that drives `sck` 1→0, except after the last bit.
- Counters:
  - Half-period counter is DIV_W bits and reloads to req_div at each half boundary.
  - Bit counter is LEN_W bits and counts down from len.
  - Neither counter wraps within a transfer.
- `req_*` inputs are ignored outside IDLE. `resp_data` is stable while `resp_valid` is high.

## Timing
- Accept edge = cycle 0.
- Cycle 1: `ss_n` asserted, first `mosi` bit valid, `sck`=0.
- `sck` rises at cycles 1+H+2kH for k=0..len-1 and falls H cycles after each rise.
- `resp_valid` rises and `ss_n` deasserts at cycle 1+H+2·len·H. Example: div=0, len=8 gives cycle 18.
- The response handshake completes at the first edge with `resp_valid && resp_ready`. `req_ready` is 1 on the following cycle.
- Back-to-back transfers keep `ss_n` deasserted for at least 2 cycles (RESP plus IDLE).
- Slave setup: `mosi` is stable H cycles before every `sck` rise. Slave hold: `ss_n` stays asserted H cycles after the last `sck` fall.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`, when defined:
  - The first bit sent is req_data[0].
  - Received bits enter at bit len-1 and shift right, so resp_data[0] is the first bit received.
- When undefined: MSB-first as described in Operation.
- Timing is identical in both builds.

## Test plan
- Loopback (`mosi`→`miso`), req_data=0x00A5, len=8, div=0, ss=0x01: `ss_n`=0xFE from cycle 1. Eight `sck` pulses each 1 cycle high. `resp_valid` at cycle 18 with resp_data=0x00A5. `ss_n`=0xFF at that cycle.
- Slave model driving `miso`=1 constantly, len=16, div=3: `sck` high/low halves are each 4 cycles. `resp_valid` at cycle 133 with resp_data=0xFFFF.
- len=0 and len=20 with DATA_W=16: both run 16 bit periods. Loopback returns req_data unchanged.
- Hold `resp_ready`=0 for 10 cycles after `resp_valid`: `resp_valid` and `resp_data` stay stable, `req_ready`=0, and a new `req_valid` is not accepted. Release: `req_ready`=1 on the next cycle.
- Assert `reset` for 1 cycle at cycle 7 of a len=8 div=0 transfer: next cycle `sck`=0, `ss_n`=0xFF, `mosi`=1, `req_ready`=1, `resp_valid` never asserts.
- Build with `SPI_MASTER_LSB_FIRST_EN`, loopback, req_data=0x0001, len=8: `mosi` is 1 during the first bit period only. resp_data=0x0001.
